// File: rtl/axi_defs.sv
// Shared AXI4 constants and bridge state encoding for the data-cache bridge.
// Single-beat, single-outstanding transactions only.
package axi_defs;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AD = 3'd3,
        WR_B  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [7:0] LEN_SINGLE   = 8'd0;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic       LOCK_NORMAL  = 1'b0;
    localparam logic [3:0] CACHE_NONE   = 4'b0000;
    localparam logic [2:0] PROT_NONE    = 3'b000;
    localparam logic       WLAST_SINGLE = 1'b1;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/d_cache_axi_bridge_if.sv
// Cache request port plus AXI4 master channels of the data-cache bridge.
// master = bridge view; slave = cache + interconnect view.
interface d_cache_axi_bridge_if #(parameter int A_WIDTH = 32);

    logic [A_WIDTH-1:0] c_a;
    logic [31:0]        c_din;
    logic [31:0]        c_dout;
    logic               c_strobe;
    logic [3:0]         c_wen;
    logic [1:0]         c_size;
    logic               c_rw;
    logic               c_ready;
    logic               bus_err;

    logic [3:0]         arid;
    logic [A_WIDTH-1:0] araddr;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic               arlock;
    logic [3:0]         arcache;
    logic [2:0]         arprot;
    logic               arvalid;
    logic               arready;
    logic [31:0]        rdata;
    logic [1:0]         rresp;
    logic               rvalid;
    logic               rready;

    logic [3:0]         awid;
    logic [A_WIDTH-1:0] awaddr;
    logic [7:0]         awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst;
    logic               awlock;
    logic [3:0]         awcache;
    logic [2:0]         awprot;
    logic               awvalid;
    logic               awready;
    logic [31:0]        wdata;
    logic [3:0]         wstrb;
    logic               wlast;
    logic               wvalid;
    logic               wready;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready;

    modport master (
        input  c_a, c_din, c_strobe, c_wen, c_size, c_rw,
        output c_dout, c_ready, bus_err,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready, rdata, rresp, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready, bresp, bvalid,
        output bready
    );

    modport slave (
        output c_a, c_din, c_strobe, c_wen, c_size, c_rw,
        input  c_dout, c_ready, bus_err,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready, rdata, rresp, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/d_cache_axi_bridge.sv
// Turns one cache request into one single-beat AXI4 read or write; min latency 4 cycles strobe->c_ready.
// One transaction in flight; AXI valids are pure state decode and hold until each channel's ready.
module d_cache_axi_bridge
    import axi_defs::*;
#(
    parameter int         A_WIDTH = 32,
    parameter logic [3:0] AXI_ID  = 4'd1
) (
    input  logic                 clk,
    input  logic                 clrn,
    d_cache_axi_bridge_if.master bus
);

    state_t             state, state_nxt;
    logic [A_WIDTH-1:0] addr_q;
    logic [31:0]        din_q;
    logic [3:0]         wen_q;
    logic [1:0]         size_q;
    logic [31:0]        dout_q;
    logic               err_q;
    logic               aw_done, w_done;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.c_strobe) state_nxt = bus.c_rw ? WR_AD : RD_A;
            RD_A:    if (bus.arready)  state_nxt = RD_D;
            RD_D:    if (bus.rvalid)   state_nxt = DONE;
            // AW and W may complete in either order or together
            WR_AD:   if ((aw_done || bus.awready) && (w_done || bus.wready)) state_nxt = WR_B;
            WR_B:    if (bus.bvalid)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            addr_q  <= '0;
            din_q   <= '0;
            wen_q   <= '0;
            size_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.c_strobe) begin
                    addr_q  <= bus.c_a;
                    din_q   <= bus.c_din;
                    wen_q   <= bus.c_wen;
                    size_q  <= bus.c_size;
                    err_q   <= 1'b0;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                RD_D: if (bus.rvalid) begin
                    dout_q <= bus.rdata;
                    err_q  <= resp_is_err(bus.rresp);
                end
                WR_AD: begin
                    if (!aw_done && bus.awready) aw_done <= 1'b1;
                    if (!w_done && bus.wready)   w_done  <= 1'b1;
                end
                WR_B: if (bus.bvalid) err_q <= resp_is_err(bus.bresp);
                default: ;
            endcase
        end
    end

    assign bus.c_dout  = dout_q;
    assign bus.c_ready = (state == DONE);
    assign bus.bus_err = (state == DONE) && err_q;

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = LEN_SINGLE;
    assign bus.arsize  = {1'b0, size_q};
    assign bus.arburst = BURST_INCR;
    assign bus.arlock  = LOCK_NORMAL;
    assign bus.arcache = CACHE_NONE;
    assign bus.arprot  = PROT_NONE;
    assign bus.arvalid = (state == RD_A);
    assign bus.rready  = (state == RD_D);

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = LEN_SINGLE;
    assign bus.awsize  = {1'b0, size_q};
    assign bus.awburst = BURST_INCR;
    assign bus.awlock  = LOCK_NORMAL;
    assign bus.awcache = CACHE_NONE;
    assign bus.awprot  = PROT_NONE;
    assign bus.awvalid = (state == WR_AD) && !aw_done;
    assign bus.wdata   = din_q;
    assign bus.wstrb   = wen_q;
    assign bus.wlast   = WLAST_SINGLE;
    assign bus.wvalid  = (state == WR_AD) && !w_done;
    assign bus.bready  = (state == WR_B);

endmodule

// File: tb/tb_d_cache_axi_bridge.sv
// Directed bench for d_cache_axi_bridge: a transaction-level model of the expected request,
// a delay-programmable AXI slave and a per-cycle compare process on the falling edge.
module tb_d_cache_axi_bridge;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    d_cache_axi_bridge_if #(.A_WIDTH(32)) bus ();

    d_cache_axi_bridge #(.A_WIDTH(32), .AXI_ID(4'd1)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // expected transaction and programmed slave delays
    logic        cur_rw;
    logic [31:0] cur_a, cur_din, cur_rdata;
    logic [3:0]  cur_wen;
    logic [1:0]  cur_size, cur_resp;
    int d_ar, d_r, d_aw, d_w, d_b, exp_lat;
    bit busy = 1'b0;
    int cyc;
    int ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int arv_cyc, awv_cyc, wv_cyc;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    int lat_obs;
    logic [31:0] dout_obs, ar_addr_obs, aw_addr_obs;
    logic        err_obs;
    logic [2:0]  ar_size_obs, aw_size_obs;

    always @(negedge clk) begin
        if (!clrn) begin
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (bus.bus_err) chk("bus_err_without_ready", 32'(bus.c_ready), 32'd1);
            if (!busy)
                chk("idle_quiet", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
            if (bus.arvalid) begin
                arv_cyc++;
                chk("araddr", bus.araddr, cur_a);
                chk("arsize", 32'(bus.arsize), 32'({1'b0, cur_size}));
            end
            if (bus.awvalid) begin
                awv_cyc++;
                chk("awaddr", bus.awaddr, cur_a);
                chk("awsize", 32'(bus.awsize), 32'({1'b0, cur_size}));
            end
            if (bus.wvalid) begin
                wv_cyc++;
                chk("wdata", bus.wdata, cur_din);
                chk("wstrb", 32'(bus.wstrb), 32'(cur_wen));
                chk("wlast", 32'(bus.wlast), 32'd1);
            end

            // slave responses for the coming edge
            bus.arready = bus.arvalid && (ar_cnt >= d_ar);
            if (bus.arready) begin
                ar_hs++; ar_cnt = 0; ar_addr_obs = bus.araddr; ar_size_obs = bus.arsize;
            end else if (bus.arvalid) ar_cnt++;
            bus.rvalid = bus.rready && (r_cnt >= d_r);
            bus.rdata  = bus.rvalid ? cur_rdata : 32'h0;
            bus.rresp  = bus.rvalid ? cur_resp : 2'b00;
            if (bus.rvalid) begin r_hs++; r_cnt = 0; end else if (bus.rready) r_cnt++;
            bus.awready = bus.awvalid && (aw_cnt >= d_aw);
            if (bus.awready) begin
                aw_hs++; aw_cnt = 0; aw_addr_obs = bus.awaddr; aw_size_obs = bus.awsize;
            end else if (bus.awvalid) aw_cnt++;
            bus.wready = bus.wvalid && (w_cnt >= d_w);
            if (bus.wready) begin w_hs++; w_cnt = 0; end else if (bus.wvalid) w_cnt++;
            bus.bvalid = bus.bready && (b_cnt >= d_b);
            bus.bresp  = bus.bvalid ? cur_resp : 2'b00;
            if (bus.bvalid) begin b_hs++; b_cnt = 0; end else if (bus.bready) b_cnt++;

            if (busy) cyc++;
            if (bus.c_ready) begin
                chk("ready_while_busy", 32'(busy), 32'd1);
                lat_obs = cyc; dout_obs = bus.c_dout; err_obs = bus.bus_err;
                chk("latency", 32'(cyc), 32'(exp_lat));
                chk("bus_err", 32'(bus.bus_err), 32'(cur_resp != 2'b00));
                if (!cur_rw) begin
                    chk("c_dout", bus.c_dout, cur_rdata);
                    chk("arvalid_cycles", 32'(arv_cyc), 32'(d_ar + 1));
                end else begin
                    chk("awvalid_cycles", 32'(awv_cyc), 32'(d_aw + 1));
                    chk("wvalid_cycles", 32'(wv_cyc), 32'(d_w + 1));
                end
                chk("ar_count", 32'(ar_hs), cur_rw ? 32'd0 : 32'd1);
                chk("r_count",  32'(r_hs),  cur_rw ? 32'd0 : 32'd1);
                chk("aw_count", 32'(aw_hs), cur_rw ? 32'd1 : 32'd0);
                chk("w_count",  32'(w_hs),  cur_rw ? 32'd1 : 32'd0);
                chk("b_count",  32'(b_hs),  cur_rw ? 32'd1 : 32'd0);
                busy = 1'b0;
            end
        end
    end

    task automatic start_req(input logic rw, input logic [31:0] a, input logic [31:0] din,
                             input logic [3:0] wen, input logic [1:0] size,
                             input logic [31:0] rdata, input logic [1:0] resp,
                             input int dar, input int dr, input int daw, input int dw, input int db);
        cur_rw = rw; cur_a = a; cur_din = din; cur_wen = wen; cur_size = size;
        cur_rdata = rdata; cur_resp = resp;
        d_ar = dar; d_r = dr; d_aw = daw; d_w = dw; d_b = db;
        exp_lat = rw ? 4 + ((daw > dw) ? daw : dw) + db : 4 + dar + dr;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        arv_cyc = 0; awv_cyc = 0; wv_cyc = 0;
        bus.c_a = a; bus.c_din = din; bus.c_wen = wen; bus.c_size = size; bus.c_rw = rw;
        bus.c_strobe = 1'b1;
        cyc = 0;
        busy = 1'b1;
    endtask

    // returns at posedge+1 of the IDLE cycle following DONE
    task automatic wait_done(input bit keep);
        int t = 0;
        while (busy && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("done_within_budget", 32'(busy), 32'd0);
        busy = 1'b0;
        @(posedge clk); #1;
        if (!keep) bus.c_strobe = 1'b0;
    endtask

    task automatic run_req(input logic rw, input logic [31:0] a, input logic [31:0] din,
                           input logic [3:0] wen, input logic [1:0] size,
                           input logic [31:0] rdata, input logic [1:0] resp,
                           input int dar, input int dr, input int daw, input int dw, input int db,
                           input bit keep);
        start_req(rw, a, din, wen, size, rdata, resp, dar, dr, daw, dw, db);
        wait_done(keep);
    endtask

    initial begin
        clrn = 1'b0;
        bus.c_a = '0; bus.c_din = '0; bus.c_wen = '0; bus.c_size = '0; bus.c_rw = 1'b0;
        bus.c_strobe = 1'b0;
        d_ar = 0; d_r = 0; d_aw = 0; d_w = 0; d_b = 0;
        cur_rw = 1'b0; cur_a = '0; cur_din = '0; cur_wen = '0; cur_size = '0;
        cur_rdata = '0; cur_resp = '0;
        #1;
        chk("rst_valids", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
        chk("rst_c_ready", 32'({bus.c_ready, bus.bus_err}), 32'd0);
        chk("rst_c_dout", bus.c_dout, 32'h0);
        chk("rst_addr", bus.araddr | bus.awaddr, 32'h0);
        chk("rst_wdata_wstrb", bus.wdata | 32'(bus.wstrb), 32'h0);
        chk("axi_ids", 32'({bus.arid, bus.awid}), 32'h11);
        chk("axi_len_burst", 32'({bus.arlen, bus.awlen, bus.arburst, bus.awburst}), 32'h0005);
        chk("axi_lock_cache_prot", 32'({bus.arlock, bus.awlock, bus.arcache, bus.awcache,
                                        bus.arprot, bus.awprot}), 32'h0);
        repeat (2) @(posedge clk);
        #2 clrn = 1'b1;
        @(posedge clk); #1;

        // read, immediate slave
        run_req(1'b0, 32'h1FC0_0010, 32'h0, 4'h0, 2'd2, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 1'b0);
        chk("rd_hit_latency", 32'(lat_obs), 32'd4);
        chk("rd_hit_dout", dout_obs, 32'hDEAD_BEEF);
        chk("rd_hit_araddr", ar_addr_obs, 32'h1FC0_0010);
        chk("rd_hit_arsize", 32'(ar_size_obs), 32'd2);
        repeat (3) @(posedge clk); #1;

        // stalled read
        run_req(1'b0, 32'h0000_1236, 32'h0, 4'h0, 2'd1, 32'h1234_5678, 2'b00, 3, 5, 0, 0, 0, 1'b0);
        chk("rd_stall_latency", 32'(lat_obs), 32'd12);
        chk("rd_stall_arvalid_cycles", 32'(arv_cyc), 32'd4);
        chk("rd_stall_ar_count", 32'(ar_hs), 32'd1);
        repeat (3) @(posedge clk); #1;

        // byte write, W accepted two cycles before AW
        run_req(1'b1, 32'h8000_0003, 32'h0000_00AB, 4'b0001, 2'd0, 32'h0, 2'b00, 0, 0, 2, 0, 0, 1'b0);
        chk("wr_byte_latency", 32'(lat_obs), 32'd6);
        chk("wr_byte_wvalid_cycles", 32'(wv_cyc), 32'd1);
        chk("wr_byte_awvalid_cycles", 32'(awv_cyc), 32'd3);
        chk("wr_byte_awaddr", aw_addr_obs, 32'h8000_0003);
        chk("wr_byte_awsize", 32'(aw_size_obs), 32'd0);

        // back-to-back read then write with strobe held
        run_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 2'd2, 32'hCAFE_F00D, 2'b00, 0, 0, 0, 0, 0, 1'b1);
        chk("b2b_rd_dout", dout_obs, 32'hCAFE_F00D);
        run_req(1'b1, 32'h0000_0204, 32'h1122_3344, 4'hF, 2'd2, 32'h0, 2'b00, 0, 0, 0, 0, 0, 1'b0);
        chk("b2b_wr_latency", 32'(lat_obs), 32'd4);
        repeat (2) @(posedge clk); #1;

        // write error then clean read
        run_req(1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'hF, 2'd2, 32'h0, 2'b10, 0, 0, 1, 1, 2, 1'b0);
        chk("wr_err_flag", 32'(err_obs), 32'd1);
        chk("wr_err_latency", 32'(lat_obs), 32'd7);
        run_req(1'b0, 32'h0000_0304, 32'h0, 4'h0, 2'd2, 32'h0BAD_F00D, 2'b00, 1, 0, 0, 0, 0, 1'b0);
        chk("after_err_flag", 32'(err_obs), 32'd0);

        // read error still returns data
        run_req(1'b0, 32'h0000_0400, 32'h0, 4'h0, 2'd2, 32'hBADB_AD00, 2'b11, 0, 2, 0, 0, 0, 1'b0);
        chk("rd_err_flag", 32'(err_obs), 32'd1);
        chk("rd_err_dout", dout_obs, 32'hBADB_AD00);

        // zero-strobe write, AW before W
        run_req(1'b1, 32'h0000_0500, 32'hFFFF_FFFF, 4'b0000, 2'd2, 32'h0, 2'b00, 0, 0, 0, 3, 1, 1'b0);
        chk("wr_nostrb_latency", 32'(lat_obs), 32'd8);

        // reset in the middle of a read data phase
        start_req(1'b0, 32'h0000_0600, 32'h0, 4'h0, 2'd2, 32'h7777_7777, 2'b00, 0, 50, 0, 0, 0);
        for (int i = 0; i < 20 && !bus.rready; i++) begin
            @(negedge clk); #1;
        end
        chk("reached_rd_d", 32'(bus.rready), 32'd1);
        #1 clrn = 1'b0;
        busy = 1'b0;
        bus.c_strobe = 1'b0;
        #1;
        chk("mid_rst_valids", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
        chk("mid_rst_c_ready", 32'({bus.c_ready, bus.bus_err}), 32'd0);
        repeat (2) @(posedge clk);
        #2 clrn = 1'b1;
        @(posedge clk); #1;
        run_req(1'b0, 32'h0000_0700, 32'h0, 4'h0, 2'd2, 32'h1357_9BDF, 2'b00, 0, 0, 0, 0, 0, 1'b0);
        chk("post_rst_latency", 32'(lat_obs), 32'd4);
        chk("post_rst_dout", dout_obs, 32'h1357_9BDF);
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
